// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared FSM state type and default build constants for the write arbiter
package dff_arb_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_HOLD_CYCLES = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first valid requester at or above ptr, wrapping, as a one-hot grant plus index
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan farthest offset first so the nearest valid index overwrites it.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
  end
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbitration of N_REQ writers onto one shared register,
// with a programmable idle gap after every write.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qb,
  output logic [$clog2(N_REQ)-1:0]   q_owner,
  output logic                       q_update,
  output logic                       busy
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_n;
  logic [3:0] hold_cnt, cnt_n;
  logic [IW-1:0] rr_ptr, idx;
  logic [N_REQ-1:0] grant;
  logic any, fire;
  rr_pick #(.N(N_REQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  // Grants are masked while reset is held so nothing is offered before release.
  assign req_ready = (reset && state == IDLE) ? grant : '0;
  assign fire = reset && state == IDLE && any;
  assign busy = reset && state == HOLD;
  assign qb = ~q;
  always_comb begin
    state_n = state;
    cnt_n = hold_cnt;
    if (state == IDLE) begin
      if (fire && HOLD_CYCLES > 0) begin
        state_n = HOLD;
        cnt_n = 4'(HOLD_CYCLES - 1);
      end
    end else begin
      state_n = (hold_cnt == '0) ? IDLE : HOLD;
      cnt_n = (hold_cnt == '0) ? hold_cnt : hold_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      rr_ptr <= '0;
      q <= '0;
      q_owner <= '0;
      q_update <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= cnt_n;
      q_update <= fire;
      if (fire) begin
        q <= req_data[int'(idx)*WIDTH +: WIDTH];
        q_owner <= idx;
        rr_ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb_dff_write_arbiter: directed stimulus on a HOLD_CYCLES=2 and a HOLD_CYCLES=0 build;
// expected writes are queued at grant time and checked when q_update pulses.
module tb_dff_write_arbiter;
  logic clk = 1'b0;
  logic reset, q_update, busy;
  logic [3:0] rv, ready;
  logic [31:0] rd;
  logic [7:0] q, qb;
  logic [1:0] owner;
  logic reset0, q_update0, busy0;
  logic [3:0] rv0, ready0;
  logic [31:0] rd0;
  logic [7:0] q0, qb0;
  logic [1:0] owner0;
  logic [9:0] sb [$];
  logic [9:0] sb0 [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dff_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(ready),
    .q(q), .qb(qb), .q_owner(owner), .q_update(q_update), .busy(busy)
  );
  dff_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset0), .req_valid(rv0), .req_data(rd0), .req_ready(ready0),
    .q(q0), .qb(qb0), .q_owner(owner0), .q_update(q_update0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Waits for the next grant on the chosen build, checking who won and how many
  // grant-free cycles preceded it, then queues the write that must follow.
  task automatic wait_grant(input bit sel, input int idx, input int gap, input logic [7:0] d);
    int n;
    logic [3:0] r;
    n = 0;
    @(negedge clk);
    r = sel ? ready0 : ready;
    while (r == 4'b0 && n < 20) begin
      n++;
      @(negedge clk);
      r = sel ? ready0 : ready;
    end
    check(sel ? "grant0" : "grant", {28'b0, r}, 32'(1) << idx);
    check(sel ? "gap0" : "gap", n, gap);
    if (r != 4'b0) begin
      if (sel) sb0.push_back({2'(idx), d});
      else sb.push_back({2'(idx), d});
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (q_update === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL update: q_update high with no write expected at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("q", {24'b0, q}, {24'b0, e[7:0]});
        check("qb", {24'b0, qb}, {24'b0, ~e[7:0]});
        check("owner", {30'b0, owner}, {30'b0, e[9:8]});
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (reset0 === 1'b1) check("busy0", {31'b0, busy0}, 32'd0);
    if (q_update0 === 1'b1) begin
      if (sb0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL update0: q_update high with no write expected at %0t", $time);
      end else begin
        e = sb0.pop_front();
        check("q0", {24'b0, q0}, {24'b0, e[7:0]});
        check("owner0", {30'b0, owner0}, {30'b0, e[9:8]});
      end
    end
  end

  initial begin
    reset = 1'b0; rv = 4'hF; rd = 32'h44332211;
    reset0 = 1'b0; rv0 = 4'h0; rd0 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {28'b0, ready}, 32'd0);
    check("rst_q", {24'b0, q}, 32'h00);
    check("rst_qb", {24'b0, qb}, 32'hFF);
    check("rst_upd", {31'b0, q_update}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_owner", {30'b0, owner}, 32'd0);
    // single requester 2
    @(posedge clk); #1 reset = 1'b1; rv = 4'h0;
    @(posedge clk); #1 rv = 4'b0100; rd = 32'h00A50000;
    wait_grant(1'b0, 2, 0, 8'hA5);
    @(posedge clk); #1 rv = 4'h0;
    @(negedge clk);
    check("hold1_busy", {31'b0, busy}, 32'd1);
    check("hold1_ready", {28'b0, ready}, 32'd0);
    check("hold1_upd", {31'b0, q_update}, 32'd1);
    @(negedge clk);
    check("hold2_busy", {31'b0, busy}, 32'd1);
    check("hold2_upd", {31'b0, q_update}, 32'd0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    // pointer sits at 3: grant 3 then wrap to 0
    @(posedge clk); #1 rv = 4'b1001; rd = 32'h330000C0;
    wait_grant(1'b0, 3, 0, 8'h33);
    wait_grant(1'b0, 0, 2, 8'hC0);
    // reset in the middle of the hold
    @(posedge clk); #1 reset = 1'b0; rv = 4'b0010; rd = 32'h00005A00;
    @(negedge clk);
    check("rst_hold_busy", {31'b0, busy}, 32'd0);
    check("rst_hold_ready", {28'b0, ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    wait_grant(1'b0, 1, 0, 8'h5A);
    check("rel_q", {24'b0, q}, 32'h00);
    check("rel_owner", {30'b0, owner}, 32'd0);
    // fresh pointer, all requesters valid
    @(posedge clk); #1 reset = 1'b0; rv = 4'h0;
    @(posedge clk); #1 reset = 1'b1; rv = 4'hF; rd = 32'hD3C2B1A0;
    wait_grant(1'b0, 0, 0, 8'hA0);
    wait_grant(1'b0, 1, 2, 8'hB1);
    wait_grant(1'b0, 2, 2, 8'hC2);
    wait_grant(1'b0, 3, 2, 8'hD3);
    wait_grant(1'b0, 0, 2, 8'hA0);
    @(posedge clk); #1 rv = 4'h0;
    // zero-hold build: back-to-back grants
    @(posedge clk); #1 reset0 = 1'b1; rv0 = 4'b0011; rd0 = 32'h00002211;
    wait_grant(1'b1, 0, 0, 8'h11);
    wait_grant(1'b1, 1, 0, 8'h22);
    wait_grant(1'b1, 0, 0, 8'h11);
    wait_grant(1'b1, 1, 0, 8'h22);
    @(posedge clk); #1 rv0 = 4'h0;
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("sb0_drained", sb0.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
